wallace_mac_sequencer: RTL and testbench

//   Sequences the combinational 8x8 Wallace tree multiplier as a multiply-accumulate engine.

---
 rtl/wallace_mac_pkg.sv | 16 +
 rtl/wallace_mac_sequencer_mult.sv | 47 ++++
 rtl/wallace_mac_sequencer.sv | 116 +++++++++++
 tb/tb_wallace_mac_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_mac_pkg.sv
// Shared definitions for the Wallace-tree multiply-accumulate sequencer.
//   - FSM state encoding (IDLE, FEED, DRAIN, DONE)
//   - default widths for the operand-pair count and the accumulator
package wallace_mac_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int ACC_W_DEF = 24;

  typedef logic [1:0] mac_state_t;

  localparam mac_state_t IDLE  = 2'd0;
  localparam mac_state_t FEED  = 2'd1;
  localparam mac_state_t DRAIN = 2'd2;
  localparam mac_state_t DONE  = 2'd3;

endpackage

// File: rtl/wallace_mac_sequencer_mult.sv
// Combinational 8x8 unsigned Wallace tree multiplier.
//   a  in  8   multiplicand
//   b  in  8   multiplier
//   p  out 16  product a*b
// Eight partial-product rows are reduced with 3:2 carry-save layers
// (8 -> 6 -> 4 -> 3 -> 2 rows), then one carry-propagate add.
// All rows are kept 16 bits wide; the true product never exceeds 16 bits,
// so bits shifted past bit 15 by the carry rows are always zero.
module wallace_mult8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] pp [8];

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = {8'b0, a & {8{b[i]}}} << i;
  end

  // Layer 1: 8 rows -> 6 rows
  logic [15:0] s0, c0, s1, c1;
  assign s0 = pp[0] ^ pp[1] ^ pp[2];
  assign c0 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
  assign s1 = pp[3] ^ pp[4] ^ pp[5];
  assign c1 = ((pp[3] & pp[4]) | (pp[3] & pp[5]) | (pp[4] & pp[5])) << 1;

  // Layer 2: s0 c0 s1 c1 pp6 pp7 -> 4 rows
  logic [15:0] s2, c2, s3, c3;
  assign s2 = s0 ^ c0 ^ s1;
  assign c2 = ((s0 & c0) | (s0 & s1) | (c0 & s1)) << 1;
  assign s3 = c1 ^ pp[6] ^ pp[7];
  assign c3 = ((c1 & pp[6]) | (c1 & pp[7]) | (pp[6] & pp[7])) << 1;

  // Layer 3: s2 c2 s3 -> 2 rows, c3 passes through
  logic [15:0] s4, c4;
  assign s4 = s2 ^ c2 ^ s3;
  assign c4 = ((s2 & c2) | (s2 & s3) | (c2 & s3)) << 1;

  // Layer 4: s4 c4 c3 -> 2 rows
  logic [15:0] s5, c5;
  assign s5 = s4 ^ c4 ^ c3;
  assign c5 = ((s4 & c4) | (s4 & c3) | (c4 & c3)) << 1;

  assign p = s5 + c5;

endmodule

// File: rtl/wallace_mac_sequencer.sv
// Multiply-accumulate sequencer around the 8x8 Wallace tree multiplier.
//   clk, rst          clock, asynchronous active-high reset
//   start, len        begin a job of len operand pairs (sampled in IDLE only)
//   busy              high in every state except IDLE
//   a_data, b_data    operand pair; op_valid / op_ready stream handshake
//   acc_out           accumulated sum (wraps modulo 2^ACC_W), held until next start
//   acc_valid         result valid (DONE); acc_ready accepts it
//   overflow          sticky per job: an accumulate carried out of ACC_W
//   dbg_state         current FSM state, for observation only
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds data stable while valid is high and not yet
// accepted, and ready never depends combinationally on valid.
module wallace_mac_sequencer
  import wallace_mac_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic [7:0]       a_data,
  input  logic [7:0]       b_data,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  mac_state_t       state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic [7:0]       a_q, b_q;
  logic             p_vld;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   acc_sum;
  logic             hs;
  logic             job_start;

  wallace_mult8 u_mult (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  assign hs        = op_valid & op_ready;
  assign job_start = (state == IDLE) & start;
  // Extra top bit of the sum is the carry out of the accumulator.
  assign acc_sum   = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len != '0) ? FEED : DONE;
      FEED:  if (hs && rem == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  if (acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state != IDLE);
    op_ready  = (state == FEED);
    acc_valid = (state == DONE);
    dbg_state = state;
  end

  // Counter, operand stage and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (job_start)  rem <= len;
      else if (hs)    rem <= rem - LEN_W'(1);

      if (hs) begin
        a_q <= a_data;
        b_q <= b_data;
      end
      p_vld <= hs;

      // p_vld is always clear in IDLE, so a job start never races an accumulate.
      if (job_start) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (p_vld) begin
        acc <= acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Bench for wallace_mac_sequencer: a 24-bit and a 16-bit accumulator instance
// share every input, so each job is checked against both widths.
module tb_wallace_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [7:0]  a_data = '0;
  logic [7:0]  b_data = '0;
  logic        op_valid = 1'b0;
  logic        acc_ready = 1'b0;

  logic        busy, op_ready, acc_valid, overflow;
  logic [23:0] acc_out;
  logic [1:0]  dbg_state;
  logic        busy_n, op_ready_n, acc_valid_n, overflow_n;
  logic [15:0] acc_out_n;
  logic [1:0]  dbg_state_n;

  int checks = 0;
  int errors = 0;

  logic [7:0] pa[$];
  logic [7:0] pb[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  wallace_mac_sequencer #(.LEN_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .a_data(a_data), .b_data(b_data), .op_valid(op_valid), .op_ready(op_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  wallace_mac_sequencer #(.LEN_W(8), .ACC_W(16)) dut_n (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy_n),
    .a_data(a_data), .b_data(b_data), .op_valid(op_valid), .op_ready(op_ready_n),
    .acc_out(acc_out_n), .acc_valid(acc_valid_n), .acc_ready(acc_ready),
    .overflow(overflow_n), .dbg_state(dbg_state_n)
  );

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic b, input logic r, input logic v);
    check({tag, ".busy"}, {31'b0, busy}, {31'b0, b});
    check({tag, ".op_ready"}, {31'b0, op_ready}, {31'b0, r});
    check({tag, ".acc_valid"}, {31'b0, acc_valid}, {31'b0, v});
    check({tag, ".busy16"}, {31'b0, busy_n}, {31'b0, b});
    check({tag, ".acc_valid16"}, {31'b0, acc_valid_n}, {31'b0, v});
  endtask

  // Reference: plain sum of products, reduced to each accumulator width.
  task automatic check_result(input string tag);
    longint sum = 0;
    foreach (pa[i]) sum += longint'(pa[i]) * longint'(pb[i]);
    check({tag, ".acc24"}, {8'b0, acc_out}, 32'(sum % (64'd1 << 24)));
    check({tag, ".ovf24"}, {31'b0, overflow}, {31'b0, sum >= (64'd1 << 24)});
    check({tag, ".acc16"}, {16'b0, acc_out_n}, 32'(sum % (64'd1 << 16)));
    check({tag, ".ovf16"}, {31'b0, overflow_n}, {31'b0, sum >= (64'd1 << 16)});
  endtask

  task automatic fill_random(input int n);
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(8'($urandom));
      pb.push_back(8'($urandom));
    end
  endtask

  // ---------------- driver ----------------
  // Runs one job over pa/pb. Gaps between pairs are drawn from [min_gap,max_gap];
  // the result is held back for 'hold' cycles. pulse_start throws stray starts
  // at FEED and DONE; ready_start raises start together with acc_ready.
  task automatic run_job(input string tag, input int min_gap, input int max_gap,
                         input int hold, input bit pulse_start, input bit ready_start);
    int n = pa.size();
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    len   = 8'($urandom);
    check_ctrl({tag, ".feed"}, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      int gap = $urandom_range(max_gap, min_gap);
      for (int g = 0; g < gap; g++) begin
        op_valid = 1'b0;
        a_data   = 8'($urandom);
        step();
      end
      op_valid = 1'b1;
      a_data   = pa[k];
      b_data   = pb[k];
      check({tag, ".op_ready_hs"}, {31'b0, op_ready}, 32'd1);
      if (pulse_start && k == 1) begin
        start = 1'b1;
        len   = 8'(n + 5);
      end
      step();
      start = 1'b0;
    end
    op_valid = 1'b0;
    a_data   = 8'($urandom);
    b_data   = 8'($urandom);
    check_ctrl({tag, ".drain"}, 1'b1, 1'b0, 1'b0);
    step();
    check_ctrl({tag, ".done"}, 1'b1, 1'b0, 1'b1);
    check_result({tag, ".res"});
    for (int h = 0; h < hold; h++) begin
      start    = pulse_start;
      op_valid = 1'b1;
      a_data   = 8'($urandom);
      b_data   = 8'($urandom);
      step();
      check_ctrl({tag, ".hold"}, 1'b1, 1'b0, 1'b1);
      check_result({tag, ".hold"});
    end
    start     = ready_start;
    op_valid  = 1'b0;
    acc_ready = 1'b1;
    step();
    start     = 1'b0;
    acc_ready = 1'b0;
    check_ctrl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
    check_result({tag, ".kept"});
    step();
    check_ctrl({tag, ".idle2"}, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    step();
    step();
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check("reset.acc24", {8'b0, acc_out}, 32'd0);
    check("reset.ovf24", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    step();

    // Basic: four pairs, op_valid held high
    pa = '{8'd3, 8'd255, 8'd0, 8'd16};
    pb = '{8'd5, 8'd255, 8'd7, 8'd16};
    run_job("basic", 0, 0, 0, 1'b0, 1'b0);
    check("basic.literal", {8'b0, acc_out}, 32'hFF10);

    // Zero length: straight to DONE, no op_ready pulse
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    check_ctrl("zero", 1'b1, 1'b0, 1'b1);
    check("zero.acc24", {8'b0, acc_out}, 32'd0);
    check("zero.ovf24", {31'b0, overflow}, 32'd0);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    check_ctrl("zero.idle", 1'b0, 1'b0, 1'b0);

    // Overflow in the 16-bit instance
    pa = '{8'd255, 8'd255};
    pb = '{8'd255, 8'd255};
    run_job("ovf", 0, 0, 0, 1'b0, 1'b0);
    check("ovf.literal16", {16'b0, acc_out_n}, 32'hFC02);
    check("ovf.flag16", {31'b0, overflow_n}, 32'd1);

    // Backpressure: 2-cycle gaps, result held 5 cycles
    fill_random(3);
    run_job("bp", 2, 2, 5, 1'b0, 1'b0);

    // Reset in the middle of FEED after two handshakes
    start = 1'b1;
    len   = 8'd4;
    step();
    start    = 1'b0;
    op_valid = 1'b1;
    a_data   = 8'd200;
    b_data   = 8'd200;
    step();
    a_data   = 8'd100;
    b_data   = 8'd100;
    step();
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_ctrl("rst_mid", 1'b0, 1'b0, 1'b0);
    check("rst_mid.acc24", {8'b0, acc_out}, 32'd0);
    check("rst_mid.acc16", {16'b0, acc_out_n}, 32'd0);
    check("rst_mid.ovf24", {31'b0, overflow}, 32'd0);
    #2;
    rst = 1'b0;
    step();
    pa = '{8'd2};
    pb = '{8'd3};
    run_job("post_rst", 0, 0, 0, 1'b0, 1'b0);
    check("post_rst.literal", {8'b0, acc_out}, 32'd6);

    // Stray starts during FEED and DONE, and start coinciding with acc_ready
    fill_random(5);
    run_job("stray", 0, 1, 3, 1'b1, 1'b1);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      fill_random($urandom_range(12, 1));
      run_job("rand", 0, 3, $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Longest legal job, back-to-back operands
    fill_random(255);
    run_job("maxlen", 0, 0, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
